mx_seu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor of the single-cycle scalar execution unit.
- Accepts one ALU instruction per cycle over a valid/ready issue handshake and taps two operands from the flat register bus.
- Computes the result and a 5-bit flag vector, then drives a one-hot register write-back (result register plus merged flag register) and a bank-qualified load address.
- Adds hazard handling: forwarding or interlock stalls; the previous generation had none.

---
 rtl/mx_seu_pkg.sv | 35 +++
 rtl/mx_seu_alu.sv | 73 +++++++
 rtl/mx_seu_pipe.sv | 179 +++++++++++++++++
 tb/tb_mx_seu_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mx_seu_pkg.sv
// Shared encodings for the pipelined scalar execution unit: opcodes, flag bit
// positions and the issue bundle captured into the execute stage.
package mx_seu_pkg;

   typedef enum logic [3:0] {
      OP_MOV = 4'h0, OP_ADD = 4'h1, OP_ADC = 4'h2, OP_SUB = 4'h3,
      OP_SBB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
      OP_NOT = 4'h8, OP_SHL = 4'h9, OP_SHR = 4'hA, OP_ROL = 4'hB,
      OP_ROR = 4'hC, OP_INC = 4'hD, OP_DEC = 4'hE, OP_CMP = 4'hF
   } seu_op_e;

   localparam int NUM_FLAGS = 5;
   localparam int FLG_P     = 0;
   localparam int FLG_V     = 1;
   localparam int FLG_N     = 2;
   localparam int FLG_C     = 3;
   localparam int FLG_Z     = 4;

   // Widest datapath/address the issue bundle can carry; narrower instances zero-extend.
   localparam int SEU_MAX_DW = 64;
   localparam int SEU_MAX_AW = 16;

   typedef struct packed {
      seu_op_e                 op;
      logic [SEU_MAX_AW-1:0]   dst;
      logic                    bank;
      logic [SEU_MAX_DW-1:0]   a;
      logic [SEU_MAX_DW-1:0]   b;
   } seu_issue_t;

   function automatic logic is_carry_op(input seu_op_e op);
      return (op == OP_ADC) || (op == OP_SBB);
   endfunction

endpackage

// File: rtl/mx_seu_alu.sv
// Combinational ALU for mx_seu_pipe: result plus {Z,C,N,V,P} flags for all
// sixteen opcodes. C is carry for add/inc and borrow for sub/dec/cmp.
module mx_seu_alu
   import mx_seu_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  seu_op_e                 op_i,
   input  logic [DATA_WIDTH-1:0]   a_i,
   input  logic [DATA_WIDTH-1:0]   b_i,
   input  logic                    cin_i,
   output logic [DATA_WIDTH-1:0]   res_o,
   output logic [NUM_FLAGS-1:0]    flags_o
);

   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH:0]   ext;
   logic [DATA_WIDTH-1:0] r;
   logic                  cy;
   logic                  ov;

   always_comb begin
      ext = '0;
      r   = a_i;
      cy  = 1'b0;
      ov  = 1'b0;
      unique case (op_i)
         OP_MOV: r = a_i;
         OP_ADD, OP_ADC: begin
            ext = {1'b0, a_i} + {1'b0, b_i} + (DATA_WIDTH+1)'((op_i == OP_ADC) && cin_i);
            r   = ext[MSB:0];
            cy  = ext[DATA_WIDTH];
            ov  = (a_i[MSB] == b_i[MSB]) && (r[MSB] != a_i[MSB]);
         end
         // Widened subtraction: the extra top bit is the unsigned borrow.
         OP_SUB, OP_SBB, OP_CMP: begin
            ext = {1'b0, a_i} - {1'b0, b_i} - (DATA_WIDTH+1)'((op_i == OP_SBB) && cin_i);
            r   = ext[MSB:0];
            cy  = ext[DATA_WIDTH];
            ov  = (a_i[MSB] != b_i[MSB]) && (r[MSB] != a_i[MSB]);
         end
         OP_AND: r = a_i & b_i;
         OP_OR:  r = a_i | b_i;
         OP_XOR: r = a_i ^ b_i;
         OP_NOT: r = ~a_i;
         OP_SHL: begin r = {a_i[MSB-1:0], 1'b0};    cy = a_i[MSB]; end
         OP_SHR: begin r = {1'b0, a_i[MSB:1]};      cy = a_i[0];   end
         OP_ROL: begin r = {a_i[MSB-1:0], a_i[MSB]}; cy = a_i[MSB]; end
         OP_ROR: begin r = {a_i[0], a_i[MSB:1]};    cy = a_i[0];   end
         OP_INC: begin
            ext = {1'b0, a_i} + (DATA_WIDTH+1)'(1);
            r   = ext[MSB:0];
            cy  = ext[DATA_WIDTH];
            ov  = ~a_i[MSB] & r[MSB];
         end
         OP_DEC: begin
            ext = {1'b0, a_i} - (DATA_WIDTH+1)'(1);
            r   = ext[MSB:0];
            cy  = ext[DATA_WIDTH];
            ov  = a_i[MSB] & ~r[MSB];
         end
      endcase
   end

   assign res_o          = r;
   assign flags_o[FLG_Z] = ~|r;
   assign flags_o[FLG_C] = cy;
   assign flags_o[FLG_N] = r[MSB];
   assign flags_o[FLG_V] = ov;
   assign flags_o[FLG_P] = ~^r;

endmodule

// File: rtl/mx_seu_pipe.sv
// Two-stage (execute / write-back) scalar execution unit with register-bus taps.
// Define MX_SEU_FWD_EN to resolve hazards by bypass instead of interlock stalls.
module mx_seu_pipe
   import mx_seu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int FLAG_IDX   = 7,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          fetch,
   input  logic                          ldi,
   input  logic [DATA_WIDTH-1:0]         ldv,
   input  logic [3:0]                    opcode,
   input  logic [AW-1:0]                 src_a,
   input  logic [AW-1:0]                 src_b,
   input  logic [AW-1:0]                 dst_f,
   input  logic [DEPTH*DATA_WIDTH-1:0]   reg_line,
   output logic [DEPTH-1:0]              wr_en,
   output logic [DEPTH*DATA_WIDTH-1:0]   data_line,
   output logic [AW:0]                   load_addr,
   output logic                          wb_valid,
   output logic                          busy
);

   localparam logic [AW-1:0] FLG_REG = AW'(FLAG_IDX);

   function automatic logic [DATA_WIDTH-1:0] tap(input logic [DEPTH*DATA_WIDTH-1:0] bus,
                                                 input logic [AW-1:0] idx);
      return bus[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
   endfunction

   // An in-flight entry writes register r if r is its destination or the flag register.
   function automatic logic hits(input logic vld, input seu_op_e op,
                                 input logic [AW-1:0] dst, input logic [AW-1:0] r);
      return vld && (((r == dst) && (op != OP_CMP)) || (r == FLG_REG));
   endfunction

   function automatic logic [DATA_WIDTH-1:0] fwd_val(input seu_op_e op, input logic [AW-1:0] dst,
                                                     input logic [AW-1:0] r,
                                                     input logic [DATA_WIDTH-1:0] res,
                                                     input logic [DATA_WIDTH-1:0] flagreg);
      return ((r == dst) && (op != OP_CMP)) ? res : flagreg;
   endfunction

   logic                  e_vld_q, w_vld_q, rdy_q;
   seu_issue_t            e_q, iss_d;
   logic [DATA_WIDTH-1:0] w_res_q;
   logic [NUM_FLAGS-1:0]  w_flags_q;
   logic [AW-1:0]         w_dst_q;
   logic                  w_bank_q;
   seu_op_e               w_op_q;

   seu_op_e               in_op, e_op;
   logic [AW-1:0]         e_dst;
   logic [DATA_WIDTH-1:0] e_a, e_b, e_res;
   logic [NUM_FLAGS-1:0]  e_flags;
   logic [DATA_WIDTH-1:0] flag_lane, w_flagreg, flag_base;
   logic [DATA_WIDTH-1:0] op_a, op_b;
   logic                  acc;
   logic                  unused_hi;

   assign in_op     = seu_op_e'(opcode);
   assign e_op      = e_q.op;
   assign e_dst     = e_q.dst[AW-1:0];
   assign e_a       = e_q.a[DATA_WIDTH-1:0];
   assign e_b       = e_q.b[DATA_WIDTH-1:0];
   assign unused_hi = ^{e_q.a, e_q.b, e_q.dst};

   // Architecturally latest flag register: what it holds once W has retired.
   assign flag_lane = tap(reg_line, FLG_REG);
   assign w_flagreg = ((w_op_q != OP_CMP) && (w_dst_q == FLG_REG)) ? w_res_q
                    : {flag_lane[DATA_WIDTH-1:NUM_FLAGS], w_flags_q};
   assign flag_base = w_vld_q ? w_flagreg : flag_lane;

   mx_seu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .op_i    (e_op),
      .a_i     (e_a),
      .b_i     (e_b),
      .cin_i   (flag_base[FLG_C]),
      .res_o   (e_res),
      .flags_o (e_flags)
   );

`ifdef MX_SEU_FWD_EN
   logic [DATA_WIDTH-1:0] e_flagreg;
   logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

   assign e_flagreg = ((e_op != OP_CMP) && (e_dst == FLG_REG)) ? e_res
                    : {flag_base[DATA_WIDTH-1:NUM_FLAGS], e_flags};

   // W first, then E overrides: the younger producer wins.
   always_comb begin
      fwd_a = tap(reg_line, src_a);
      fwd_b = tap(reg_line, src_b);
      if (hits(w_vld_q, w_op_q, w_dst_q, src_a)) fwd_a = fwd_val(w_op_q, w_dst_q, src_a, w_res_q, w_flagreg);
      if (hits(w_vld_q, w_op_q, w_dst_q, src_b)) fwd_b = fwd_val(w_op_q, w_dst_q, src_b, w_res_q, w_flagreg);
      if (hits(e_vld_q, e_op, e_dst, src_a))     fwd_a = fwd_val(e_op, e_dst, src_a, e_res, e_flagreg);
      if (hits(e_vld_q, e_op, e_dst, src_b))     fwd_b = fwd_val(e_op, e_dst, src_b, e_res, e_flagreg);
   end

   assign op_a     = ldi ? ldv : fwd_a;
   assign op_b     = fwd_b;
   assign in_ready = rdy_q;
`else
   logic haz_a, haz_b, haz_f;

   assign haz_a = !ldi && (hits(e_vld_q, e_op, e_dst, src_a) || hits(w_vld_q, w_op_q, w_dst_q, src_a));
   assign haz_b = hits(e_vld_q, e_op, e_dst, src_b) || hits(w_vld_q, w_op_q, w_dst_q, src_b);
   // Every op writes the flag register, so a carry consumer waits for an empty pipe.
   assign haz_f = is_carry_op(in_op) && (e_vld_q || w_vld_q);

   assign op_a     = ldi ? ldv : tap(reg_line, src_a);
   assign op_b     = tap(reg_line, src_b);
   assign in_ready = rdy_q && !(haz_a || haz_b || haz_f);
`endif

   assign acc = in_valid && in_ready;

   always_comb begin
      iss_d      = '0;
      iss_d.op   = in_op;
      iss_d.dst  = SEU_MAX_AW'(dst_f);
      iss_d.bank = fetch && (opcode != 4'h0);
      iss_d.a    = SEU_MAX_DW'(op_a);
      iss_d.b    = SEU_MAX_DW'(op_b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q   <= 1'b0;
         e_vld_q <= 1'b0;
         w_vld_q <= 1'b0;
      end else begin
         rdy_q   <= 1'b1;
         e_vld_q <= acc;
         w_vld_q <= e_vld_q;
      end
   end

   // ---- issue -> E, E -> W data registers (qualified by the valid bits) ----
   always_ff @(posedge clk) begin
      if (acc) e_q <= iss_d;
      if (e_vld_q) begin
         w_res_q   <= e_res;
         w_flags_q <= e_flags;
         w_dst_q   <= e_dst;
         w_bank_q  <= e_q.bank;
         w_op_q    <= e_op;
      end
   end

   // ---- W: write-back strobes and lane data ----
   always_comb begin
      wr_en     = '0;
      data_line = '0;
      load_addr = '0;
      if (w_vld_q) begin
         load_addr = {w_bank_q, w_dst_q};
         if (w_op_q != OP_CMP) begin
            wr_en[w_dst_q] = 1'b1;
            data_line[int'(w_dst_q)*DATA_WIDTH +: DATA_WIDTH] = w_res_q;
         end
         if ((w_op_q == OP_CMP) || (w_dst_q != FLG_REG)) begin
            wr_en[FLG_REG] = 1'b1;
            data_line[FLAG_IDX*DATA_WIDTH +: DATA_WIDTH] =
               {flag_lane[DATA_WIDTH-1:NUM_FLAGS], w_flags_q};
         end
      end
   end

   assign wb_valid = w_vld_q;
   assign busy     = e_vld_q || w_vld_q;

endmodule

// File: tb/tb_mx_seu_pipe.sv
// Directed bench for mx_seu_pipe (default 8-bit, 16-register, flag register 7);
// a small register-file model closes the write-back loop onto reg_line.
module tb_mx_seu_pipe;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid, in_ready, fetch, ldi, wb_valid, busy;
   logic [7:0]   ldv;
   logic [3:0]   opcode, src_a, src_b, dst_f;
   logic [127:0] reg_line, data_line;
   logic [15:0]  wr_en;
   logic [4:0]   load_addr;
   logic [7:0]   rf [16];

   int n_checks = 0;
   int n_err    = 0;

   mx_seu_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fetch     (fetch),
      .ldi       (ldi),
      .ldv       (ldv),
      .opcode    (opcode),
      .src_a     (src_a),
      .src_b     (src_b),
      .dst_f     (dst_f),
      .reg_line  (reg_line),
      .wr_en     (wr_en),
      .data_line (data_line),
      .load_addr (load_addr),
      .wb_valid  (wb_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int i);
      case (i)
         2:       return 8'h7F;
         3:       return 8'h01;
         7:       return 8'hA0;
         10:      return 8'h10;
         11:      return 8'h20;
         12:      return 8'h81;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 16; i++) begin
         if (!rst_n)        rf[i] <= init_val(i);
         else if (wr_en[i]) rf[i] <= data_line[i*8 +: 8];
      end
   end

   always_comb begin
      reg_line = '0;
      for (int i = 0; i < 16; i++) reg_line[i*8 +: 8] = rf[i];
   end

   function automatic logic [127:0] lanes(input int i1, input logic [7:0] v1,
                                          input int i2, input logic [7:0] v2);
      logic [127:0] r;
      r = '0;
      if (i1 >= 0) r[i1*8 +: 8] = v1;
      if (i2 >= 0) r[i2*8 +: 8] = v2;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] d, input logic l, input logic [7:0] lv, input logic f);
      in_valid = 1'b1; opcode = op; src_a = sa; src_b = sb; dst_f = d;
      ldi = l; ldv = lv; fetch = f;
   endtask

   task automatic idle;
      in_valid = 1'b0; opcode = 4'h0; src_a = 4'h0; src_b = 4'h0; dst_f = 4'h0;
      ldi = 1'b0; ldv = 8'h00; fetch = 1'b0;
   endtask

   initial begin
      idle();
      step(); step();
      chk("rst_wr_en",     wr_en, 0);
      chk("rst_data_line", data_line, 0);
      chk("rst_load_addr", load_addr, 0);
      chk("rst_wb_valid",  wb_valid, 0);
      chk("rst_busy",      busy, 0);
      chk("rst_in_ready",  in_ready, 0);
      rst_n = 1'b1;
      step();

      // ADD r1 = r2 + r3 : 0x7F + 0x01
      drive(4'h1, 4'd2, 4'd3, 4'd1, 1'b0, 8'h00, 1'b0); #1;
      chk("add_ready", in_ready, 1);
      step();
      idle(); #1;
      chk("add_e_busy",  busy, 1);
      chk("add_e_wb",    wb_valid, 0);
      chk("add_e_wr_en", wr_en, 0);
      step();
      chk("add_wr_en",  wr_en, 16'h0082);
      chk("add_data",   data_line, lanes(1, 8'h80, 7, 8'hA6));
      chk("add_laddr",  load_addr, 5'h01);
      chk("add_wbv",    wb_valid, 1);
      step();
      chk("add_drain_wr_en", wr_en, 0);
      chk("add_drain_busy",  busy, 0);

      // SUB r6 = r0 - r3, then ADC r8 = r0 + r0 + C
      drive(4'h3, 4'd0, 4'd3, 4'd6, 1'b0, 8'h00, 1'b0); #1;
      chk("sub_ready", in_ready, 1);
      step();
      drive(4'h2, 4'd0, 4'd0, 4'd8, 1'b0, 8'h00, 1'b0); #1;
`ifndef MX_SEU_FWD_EN
      chk("adc_stall1", in_ready, 0);
      step();
      chk("adc_stall2", in_ready, 0);
      chk("sub_wr_en",  wr_en, 16'h00C0);
      chk("sub_data",   data_line, lanes(6, 8'hFF, 7, 8'hAD));
      step();
      chk("adc_release", in_ready, 1);
      step();
      idle(); #1;
      step();
`else
      chk("adc_nostall", in_ready, 1);
      step();
      idle(); #1;
      chk("sub_wr_en",  wr_en, 16'h00C0);
      chk("sub_data",   data_line, lanes(6, 8'hFF, 7, 8'hAD));
      step();
`endif
      chk("adc_wr_en", wr_en, 16'h0180);
      chk("adc_data",  data_line, lanes(8, 8'h01, 7, 8'hA0));
      chk("adc_laddr", load_addr, 5'h08);
      step();
      chk("adc_drain_busy", busy, 0);

      // MOV r4 <- 0x55 (immediate), then XOR r5 = r4 ^ r4
      drive(4'h0, 4'd0, 4'd0, 4'd4, 1'b1, 8'h55, 1'b0); #1;
      chk("mov_ready", in_ready, 1);
      step();
      drive(4'h7, 4'd4, 4'd4, 4'd5, 1'b0, 8'h00, 1'b0); #1;
`ifndef MX_SEU_FWD_EN
      chk("xor_stall1", in_ready, 0);
      step();
      chk("xor_stall2", in_ready, 0);
      chk("mov_wr_en",  wr_en, 16'h0090);
      chk("mov_data",   data_line, lanes(4, 8'h55, 7, 8'hA1));
      step();
      chk("xor_release", in_ready, 1);
      step();
      idle(); #1;
      step();
`else
      chk("xor_nostall", in_ready, 1);
      step();
      idle(); #1;
      chk("mov_wr_en",  wr_en, 16'h0090);
      chk("mov_data",   data_line, lanes(4, 8'h55, 7, 8'hA1));
      step();
`endif
      chk("xor_wr_en", wr_en, 16'h00A0);
      chk("xor_data",  data_line, lanes(5, 8'h00, 7, 8'hB1));
      step();

      // CMP r10, r11 with dst 3: flags only
      drive(4'hF, 4'd10, 4'd11, 4'd3, 1'b0, 8'h00, 1'b0); #1;
      step();
      idle(); #1;
      step();
      chk("cmp_wr_en", wr_en, 16'h0080);
      chk("cmp_data",  data_line, lanes(7, 8'hAD, -1, 8'h00));
      chk("cmp_laddr", load_addr, 5'h03);
      step();

      // SHL r7 <- r12 with fetch: full result replaces the flag register
      drive(4'h9, 4'd12, 4'd12, 4'd7, 1'b0, 8'h00, 1'b1); #1;
      step();
      idle(); #1;
      step();
      chk("shl_wr_en", wr_en, 16'h0080);
      chk("shl_data",  data_line, lanes(7, 8'h02, -1, 8'h00));
      chk("shl_laddr", load_addr, 5'h17);
      chk("shl_wbv",   wb_valid, 1);
      step();

      // Two ADDs in flight, then asynchronous reset
      drive(4'h1, 4'd2, 4'd3, 4'd1, 1'b0, 8'h00, 1'b0); #1;
      step();
      drive(4'h1, 4'd2, 4'd3, 4'd9, 1'b0, 8'h00, 1'b0); #1;
      chk("rst2_ready", in_ready, 1);
      step();
      idle(); #1;
      chk("pre_rst_wr_en", wr_en, 16'h0082);
      chk("pre_rst_data",  data_line, lanes(1, 8'h80, 7, 8'h06));
      chk("pre_rst_busy",  busy, 1);
      rst_n = 1'b0; #1;
      chk("arst_wr_en",     wr_en, 0);
      chk("arst_data_line", data_line, 0);
      chk("arst_busy",      busy, 0);
      chk("arst_wb_valid",  wb_valid, 0);
      chk("arst_load_addr", load_addr, 0);
      step(); step();
      rst_n = 1'b1; #1;
      step();
      chk("post_rst_wr_en", wr_en, 0);
      chk("post_rst_busy",  busy, 0);
      chk("post_rst_ready", in_ready, 1);
      step();
      chk("post_rst_wr_en2", wr_en, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
